// File: rtl/proc_sequencer.sv
// Multi-cycle control sequencer for the load/store datapath: owns PC, IR and
// the retired counter, and decodes BRAM/regfile strobes from registered state.
module proc_sequencer #(
  parameter int RAM_WIDTH       = 32,
  parameter int RAM_ADDR_BITS   = 9,
  parameter int PROG_START_ADDR = 0,
  parameter int PROG_END_ADDR   = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     step,
  input  logic [RAM_WIDTH-1:0]     prog_data,
  output logic [RAM_ADDR_BITS-1:0] prog_addr,
  output logic                     prog_en,
  output logic [RAM_WIDTH-1:0]     ir,
  output logic                     rf_wr_en,
  output logic                     wb_sel_mem,
  output logic                     dmem_wr_en,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;

  localparam logic [4:0] OP_NAND = 5'd3;
  localparam logic [4:0] OP_LW   = 5'd4;
  localparam logic [4:0] OP_SW   = 5'd5;
  localparam logic [4:0] OP_HALT = 5'd31;

  state_t                   r_state;
  state_t                   w_next;
  logic [RAM_ADDR_BITS-1:0] r_pc;
  logic [RAM_WIDTH-1:0]     r_ir;
  logic [CNT_WIDTH-1:0]     r_retired;
  logic                     r_illegal;

  logic [4:0] w_fetch_op;
  logic [4:0] w_ir_op;
  logic       w_fetch_go;
  logic       w_at_end;
  logic       w_retire;
  logic       w_restart;
  logic       w_fetch_illegal;

  assign w_fetch_op      = prog_data[RAM_WIDTH-1 -: 5];
  assign w_ir_op         = r_ir[RAM_WIDTH-1 -: 5];
  assign w_fetch_go      = !step_mode || step;
  assign w_at_end        = (r_pc == RAM_ADDR_BITS'(PROG_END_ADDR));
  assign w_restart       = ((r_state == S_IDLE) || (r_state == S_HALT)) && start;
  assign w_fetch_illegal = (w_fetch_op > OP_SW) && (w_fetch_op != OP_HALT);
  // LW retires from MEM; every other legal opcode retires from EXEC.
  assign w_retire        = ((r_state == S_EXEC) && (w_ir_op != OP_LW)) || (r_state == S_MEM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: each always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        if (w_fetch_go) w_next = S_DECODE;
      S_DECODE:       w_next = (w_fetch_op <= OP_SW) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_ir_op == OP_LW) w_next = S_MEM;
        else                  w_next = w_at_end ? S_HALT : S_FETCH;
      end
      S_MEM:          w_next = w_at_end ? S_HALT : S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    prog_en    = 1'b0;
    rf_wr_en   = 1'b0;
    wb_sel_mem = 1'b0;
    dmem_wr_en = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        busy    = 1'b1;
        prog_en = w_fetch_go;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy       = 1'b1;
        rf_wr_en   = (w_ir_op <= OP_NAND);
        dmem_wr_en = (w_ir_op == OP_SW);
      end
      S_MEM: begin
        busy       = 1'b1;
        rf_wr_en   = 1'b1;
        wb_sel_mem = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_restart) begin
        r_pc      <= RAM_ADDR_BITS'(PROG_START_ADDR);
        r_retired <= '0;
        r_illegal <= 1'b0;
      end
      if (r_state == S_DECODE) begin
        r_ir <= prog_data;
        if (w_fetch_illegal) r_illegal <= 1'b1;
      end
      if (w_retire) begin
        if (!(&r_retired)) r_retired <= r_retired + CNT_WIDTH'(1);
        if (!w_at_end)     r_pc      <= r_pc + RAM_ADDR_BITS'(1);
      end
    end
  end

  assign prog_addr = r_pc;
  assign ir        = r_ir;
  assign retired   = r_retired;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: two instances (END=5/16-bit counter and
// END=8/2-bit counter), each fed by a 1-cycle-latency program BRAM model.
module tb_proc_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: PROG_END_ADDR=5, CNT_WIDTH=16
  logic        a_start, a_step_mode, a_step;
  logic [31:0] a_prog_data;
  logic [8:0]  a_prog_addr;
  logic        a_prog_en, a_rf, a_wb, a_dm, a_busy, a_halted, a_ill;
  logic [31:0] a_ir;
  logic [15:0] a_ret;

  // Instance B: PROG_END_ADDR=8, CNT_WIDTH=2
  logic        b_start, b_step_mode, b_step;
  logic [31:0] b_prog_data;
  logic [8:0]  b_prog_addr;
  logic        b_prog_en, b_rf, b_wb, b_dm, b_busy, b_halted, b_ill;
  logic [31:0] b_ir;
  logic [1:0]  b_ret;

  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];

  proc_sequencer #(.PROG_END_ADDR(5), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .step_mode(a_step_mode), .step(a_step),
    .prog_data(a_prog_data), .prog_addr(a_prog_addr), .prog_en(a_prog_en), .ir(a_ir),
    .rf_wr_en(a_rf), .wb_sel_mem(a_wb), .dmem_wr_en(a_dm), .busy(a_busy),
    .halted(a_halted), .illegal(a_ill), .retired(a_ret)
  );

  proc_sequencer #(.PROG_END_ADDR(8), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .step_mode(b_step_mode), .step(b_step),
    .prog_data(b_prog_data), .prog_addr(b_prog_addr), .prog_en(b_prog_en), .ir(b_ir),
    .rf_wr_en(b_rf), .wb_sel_mem(b_wb), .dmem_wr_en(b_dm), .busy(b_busy),
    .halted(b_halted), .illegal(b_ill), .retired(b_ret)
  );

  always @(posedge clk) begin
    if (a_prog_en) a_prog_data <= mem_a[a_prog_addr];
    if (b_prog_en) b_prog_data <= mem_b[b_prog_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [8:0] addr);
    return {op, 18'd0, addr};
  endfunction

  logic [63:0] rf_m, dm_m, wb_m, pe_m, ht_m;
  int          excl;

  // Called in cycle 0 (#1 after an edge): pulses start, then samples cycles 1..n.
  task automatic run_a(input int n, input int step1, input int step2, input int start_pulse);
    rf_m = '0; dm_m = '0; wb_m = '0; pe_m = '0; ht_m = '0; excl = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      a_step  = (k == step1) || (k == step2);
      a_start = (k == start_pulse);
      #1;
      if (a_rf)        rf_m[k] = 1'b1;
      if (a_dm)        dm_m[k] = 1'b1;
      if (a_wb)        wb_m[k] = 1'b1;
      if (a_prog_en)   pe_m[k] = 1'b1;
      if (a_halted)    ht_m[k] = 1'b1;
      if (a_rf && a_dm) excl++;
      tick();
    end
    a_step  = 1'b0;
    a_start = 1'b0;
  endtask

  int b_writes;

  task automatic run_b(input int n);
    b_writes = 0; ht_m = '0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (b_rf || b_dm) b_writes++;
      if (b_halted)     ht_m[k] = 1'b1;
      tick();
    end
  endtask

  task automatic check_a_reset_values(input string tag);
    check({tag, "_ctl"}, {55'd0, a_prog_en, a_rf, a_wb, a_dm, a_busy, a_halted, a_ill, 1'b0}, 64'd0);
    check({tag, "_pc"},  64'(a_prog_addr), 64'd0);
    check({tag, "_ir"},  64'(a_ir), 64'd0);
    check({tag, "_ret"}, 64'(a_ret), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'hF800_0000;
      mem_b[i] = 32'hF800_0000;
    end
    mem_a[0] = ins(5'd0, 9'd0);   // ADD
    mem_a[1] = ins(5'd1, 9'd0);   // SUB
    mem_a[2] = ins(5'd2, 9'd0);   // MUL
    mem_a[3] = ins(5'd3, 9'd0);   // NAND
    mem_a[4] = ins(5'd5, 9'd17);  // SW
    mem_a[5] = ins(5'd4, 9'd42);  // LW

    reset = 1'b1;
    a_start = 1'b0; a_step_mode = 1'b0; a_step = 1'b0;
    b_start = 1'b0; b_step_mode = 1'b0; b_step = 1'b0;
    tick(); tick();
    check_a_reset_values("reset");
    check("reset_b_ctl", {57'd0, b_prog_en, b_rf, b_wb, b_dm, b_busy, b_halted, b_ill}, 64'd0);
    reset = 1'b0;
    tick();

    // Run mode, six-instruction program ending at PROG_END_ADDR=5
    run_a(22, 0, 0, 0);
    check("run_rf_cycles",   rf_m, 64'h0000_0000_0008_1248);
    check("run_dm_cycles",   dm_m, 64'h0000_0000_0000_8000);
    check("run_wb_cycles",   wb_m, 64'h0000_0000_0008_0000);
    check("run_fetch_cycles", pe_m, 64'h0000_0000_0001_2492);
    check("run_halt_cycles", ht_m, 64'h0000_0000_0070_0000);
    check("run_excl",        64'(excl), 64'd0);
    check("run_retired",     64'(a_ret), 64'd6);
    check("run_pc",          64'(a_prog_addr), 64'd5);
    check("run_ir",          64'(a_ir), 64'(ins(5'd4, 9'd42)));
    check("run_busy",        64'(a_busy), 64'd0);

    // Illegal opcode 6 at address 0, restarted from HALT with pc=5
    mem_a[0] = ins(5'd6, 9'd0);
    run_a(6, 0, 0, 0);
    check("ill_halt_cycles", ht_m, 64'h0000_0000_0000_0078);
    check("ill_fetch",       pe_m, 64'h0000_0000_0000_0002);
    check("ill_writes",      rf_m | dm_m, 64'd0);
    check("ill_flag",        64'(a_ill), 64'd1);
    check("ill_retired",     64'(a_ret), 64'd0);
    check("ill_pc_reload",   64'(a_prog_addr), 64'd0);

    // Single-step: steps at cycles 10 and 30, start while busy at cycle 20
    mem_a[0] = ins(5'd0, 9'd0);
    a_step_mode = 1'b1;
    run_a(40, 10, 30, 20);
    check("step_fetch_cycles", pe_m, 64'h0000_0000_4000_0400);
    check("step_rf_cycles",    rf_m, 64'h0000_0001_0000_1000);
    check("step_retired",      64'(a_ret), 64'd2);
    check("step_pc",           64'(a_prog_addr), 64'd2);
    check("step_busy_waiting", {62'd0, a_busy, a_halted}, 64'd2);
    check("step_ill_cleared",  64'(a_ill), 64'd0);

    // Back to run mode, then reset sampled at the end of DECODE aborts the MUL
    a_step_mode = 1'b0;
    #1;
    check("resume_fetch", 64'(a_prog_en), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check_a_reset_values("abort");
    a_start = 1'b1;
    tick();
    check("reset_beats_start", {62'd0, a_busy, a_prog_en}, 64'd0);
    reset   = 1'b0;
    a_start = 1'b0;
    tick();

    // Instance B: HALT opcode at address 2
    mem_b[0] = ins(5'd0, 9'd0);
    mem_b[1] = ins(5'd1, 9'd0);
    mem_b[2] = 32'hF800_0000;
    run_b(12);
    check("hop_writes",      64'(b_writes), 64'd2);
    check("hop_halt_cycles", ht_m, 64'h0000_0000_0000_1E00);
    check("hop_retired",     64'(b_ret), 64'd2);
    check("hop_illegal",     64'(b_ill), 64'd0);
    check("hop_pc",          64'(b_prog_addr), 64'd2);

    // Instance B: five ALU instructions saturate a 2-bit counter
    mem_b[0] = ins(5'd0, 9'd0);
    mem_b[1] = ins(5'd1, 9'd0);
    mem_b[2] = ins(5'd2, 9'd0);
    mem_b[3] = ins(5'd3, 9'd0);
    mem_b[4] = ins(5'd0, 9'd0);
    mem_b[5] = 32'hF800_0000;
    run_b(25);
    check("sat_writes",  64'(b_writes), 64'd5);
    check("sat_retired", 64'(b_ret), 64'd3);
    check("sat_halted",  64'(b_halted), 64'd1);
    check("sat_pc",      64'(b_prog_addr), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
